// File: rtl/disparity_pkg.sv
// Shared types and defaults for the disparity frame writer.
package disparity_pkg;

   localparam int IMG_W       = 320;  // default pixels per line
   localparam int IMG_H       = 240;  // default lines per frame
   localparam int DMAX        = 64;   // largest disparity the core produces
   localparam int WORD_ADDR_W = 20;   // default memory word-address width

   typedef logic [7:0] disp_t;

   // One buffered SRAM write at the default address width.
   typedef struct packed {
      logic [WORD_ADDR_W-1:0] addr;
      logic [15:0]            data;
   } wr_word_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Counter width that never collapses to zero bits for tiny parameters.
   function automatic int clog2_min1(input int value);
      return (value <= 2) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/disparity_word_fifo.sv
// Synchronous first-word-fall-through FIFO with a flush that empties it in one cycle.
module disparity_word_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_data = mem[rd_ptr[AW-1:0]];

   // A push into a full FIFO is accepted only when the head leaves in the same cycle.
   always_comb begin
      rd_en = pop && !empty;
      wr_en = push && (!full || rd_en);
   end

   // Pointer update; flush overrides any push/pop in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write.
   always_ff @(posedge clk) begin
      // NOTE: storage has no reset; the pointers alone define which entries are valid.
      if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/disparity_frame_writer.sv
// Packs raster-order disparity pixels into 16-bit pairs and writes them to frame memory.
module disparity_frame_writer
   import disparity_pkg::*;
#(
   parameter int IMG_W      = disparity_pkg::IMG_W,
   parameter int IMG_H      = disparity_pkg::IMG_H,
   parameter int BASE_ADDR  = 0,
   parameter int ADDR_W     = 20,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_frame_start,
   input  logic              i_valid,
   input  disp_t             i_disparity,
   output logic              o_wr_req,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [15:0]       o_wr_data,
   input  logic              i_wr_ack,
   output logic              o_frame_done,
   output logic              o_overflow
);

   localparam int XW = clog2_min1(IMG_W);
   localparam int YW = clog2_min1(IMG_H);
   localparam int EW = ADDR_W + 16;
   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [15:0]       data;
   } entry_t;

   state_t            state;
   logic [XW-1:0]     x_cnt;
   logic [YW-1:0]     y_cnt;
   logic [ADDR_W-1:0] addr_cnt;
   disp_t             even_pix;

   entry_t            push_entry;
   logic [EW-1:0]     head_bits;
   entry_t            head_entry;
   logic              accept_pix;
   logic              last_pix;
   logic              push_req;
   logic              push_ok;
   logic              drop;
   logic              stage_free;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;

   assign head_entry = entry_t'(head_bits);

   // Pixel acceptance, word formation, FIFO handshakes; frame_start blocks pixel, pop and ack.
   always_comb begin
      // NOTE: every signal gets an unconditional value here, so no latch can be inferred.
      accept_pix = (state == RUN) && i_valid && !i_frame_start;
      last_pix   = accept_pix && (x_cnt == X_LAST) && (y_cnt == Y_LAST);
      push_req   = accept_pix && x_cnt[0];
      push_entry = '{addr: addr_cnt, data: {i_disparity, even_pix}};
      stage_free = !o_wr_req || i_wr_ack;
      fifo_pop   = stage_free && !fifo_empty && !i_frame_start;
      push_ok    = push_req && (!fifo_full || fifo_pop);
      drop       = push_req && !push_ok;
   end

   disparity_word_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .flush     (i_frame_start),
      .push      (push_ok),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .pop_data  (head_bits),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Frame FSM: pixel position, running word address, pair register, done pulse, overflow flag.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= IDLE;
         x_cnt        <= '0;
         y_cnt        <= '0;
         addr_cnt     <= '0;
         even_pix     <= '0;
         o_overflow   <= 1'b0;
         o_frame_done <= 1'b0;
      end else begin
         o_frame_done <= 1'b0;
         if (i_frame_start) begin
            state      <= RUN;
            x_cnt      <= '0;
            y_cnt      <= '0;
            addr_cnt   <= ADDR_W'(BASE_ADDR);
            even_pix   <= '0;
            o_overflow <= 1'b0;
         end else begin
            if (drop) o_overflow <= 1'b1;
            case (state)
               RUN: begin
                  if (accept_pix) begin
                     if (!x_cnt[0]) even_pix <= i_disparity;
                     else           addr_cnt <= addr_cnt + 1'b1;
                     if (last_pix) begin
                        x_cnt <= '0;
                        state <= DRAIN;
                     end else if (x_cnt == X_LAST) begin
                        x_cnt <= '0;
                        y_cnt <= y_cnt + 1'b1;
                     end else begin
                        x_cnt <= x_cnt + 1'b1;
                     end
                  end
               end
               DRAIN: begin
                  if (fifo_empty && !o_wr_req) begin
                     state        <= IDLE;
                     o_frame_done <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Registered write port: reload from the FIFO head whenever the stage is empty or acked.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_wr_req  <= 1'b0;
         o_wr_addr <= '0;
         o_wr_data <= '0;
      end else if (i_frame_start) begin
         o_wr_req  <= 1'b0;
      end else if (stage_free) begin
         o_wr_req <= !fifo_empty;
         if (!fifo_empty) begin
            o_wr_addr <= head_entry.addr;
            o_wr_data <= head_entry.data;
         end
      end
   end

endmodule
